// File: rtl/io_pkg.sv
// Shared address map, default widths and address decode for the switch/LED I/O block.
package io_pkg;

    localparam logic [31:0] LED_ADDR  = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR   = 32'hFFFF_FC70;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF_FC74;

    localparam int IO_W_DEFAULT     = 24;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LED,
        SEL_SW,
        SEL_STAT
    } io_sel_e;

    function automatic io_sel_e decode_addr(input logic [31:0] a);
        io_sel_e sel;
        sel = SEL_NONE;
        if (a == LED_ADDR) begin
            sel = SEL_LED;
        end else if (a == SW_ADDR) begin
            sel = SEL_SW;
        end else if (a == STAT_ADDR) begin
            sel = SEL_STAT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer; accept pulses on the
// cycle whose rising edge moves the candidate into stable.
module sw_debounce
    import io_pkg::*;
#(
    parameter int W               = IO_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] switch,
    output logic [W-1:0] stable,
    output logic         accept
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1_q, sync1_d;
    logic [W-1:0]     sync2_q, sync2_d;
    logic [W-1:0]     cand_q, cand_d;
    logic [W-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_d;

    // cnt only ever climbs to DEBOUNCE_CYCLES-1 before being cleared, so it cannot wrap
    always_comb begin
        sync1_d  = switch;
        sync2_d  = sync1_q;
        cand_d   = sync2_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (sync2_q != cand_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            accept_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign accept = accept_d;

endmodule

// File: rtl/switch_led_io.sv
// Memory-mapped switch/LED port: LED register, debounced switch readback and a
// sticky change flag that is cleared by reading the status address.
module switch_led_io
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int IO_W            = IO_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [IO_W-1:0] switch,
    output logic [IO_W-1:0] led,
    output logic            sw_changed
);

    io_sel_e         sel;
    logic [IO_W-1:0] stable;
    logic            accept;
    logic            stat_rd;

    logic [IO_W-1:0] led_q, led_d;
    logic            sw_changed_q, sw_changed_d;

    sw_debounce #(
        .W               (IO_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .switch (switch),
        .stable (stable),
        .accept (accept)
    );

    assign sel     = decode_addr(addr);
    assign stat_rd = io_rd && (sel == SEL_STAT);

    always_comb begin
        rdata = '0;
        if (io_rd) begin
            case (sel)
                SEL_LED:  rdata = 32'(led_q);
                SEL_SW:   rdata = 32'(stable);
                SEL_STAT: rdata = {31'b0, sw_changed_q};
                default:  rdata = '0;
            endcase
        end
    end

    // A new acceptance outranks the read-to-clear so no change event is lost
    always_comb begin
        led_d        = led_q;
        sw_changed_d = accept | (sw_changed_q & ~stat_rd);
        if (io_wr && (sel == SEL_LED)) begin
            led_d = wdata[IO_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q        <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            led_q        <= led_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    generate
        if (IO_W < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^wdata[31:IO_W];
        end
    endgenerate

    assign led        = led_q;
    assign sw_changed = sw_changed_q;

endmodule
